// File: rtl/mem_stage.sv
// Memory-access stage: one word load/store per instruction over a req/ack bus, result to writeback via valid/ready.
// Optional bus timeout enabled by defining MEM_STAGE_TIMEOUT_EN (default build waits on mem_ack indefinitely).
module mem_stage #(
  parameter int DBITS          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_load,
  input  logic             in_is_store,
  input  logic [DBITS-1:0] in_addr,
  input  logic [DBITS-1:0] in_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic             out_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [DBITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [DBITS-1:0] mem_rdata
);

  if ((DBITS % 8) != 0 || DBITS < 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_stage: DBITS must be a multiple of 8 and >= 16, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state_q;
  logic [DBITS-1:0] out_data_q;
  logic             out_err_q;
  logic             mem_we_q;
  logic [DBITS-1:0] mem_addr_q;
  logic [DBITS-1:0] mem_wdata_q;
  logic             is_mem_op;
  logic             bad_op;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0]             cnt_q;
`endif

  // Handshake signals come straight from state so no input reaches an output combinationally.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RESP);
  assign mem_req   = (state_q == REQ);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign is_mem_op = in_is_load | in_is_store;
  assign bad_op    = (in_is_load & in_is_store) | (|in_addr[1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem_op) begin
              out_data_q <= in_addr;
              out_err_q  <= 1'b0;
              state_q    <= RESP;
            end else if (bad_op) begin
              out_data_q <= '0;
              out_err_q  <= 1'b1;
              state_q    <= RESP;
            end else begin
              mem_addr_q  <= in_addr;
              mem_we_q    <= in_is_store;
              mem_wdata_q <= in_wdata;
`ifdef MEM_STAGE_TIMEOUT_EN
              cnt_q       <= '0;
`endif
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          // An ack on the final allowed cycle takes priority over the timeout.
          if (mem_ack) begin
            out_data_q <= mem_we_q ? '0 : mem_rdata;
            out_err_q  <= 1'b0;
            state_q    <= RESP;
          end
`ifdef MEM_STAGE_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            out_data_q <= '0;
            out_err_q  <= 1'b1;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset/stall/timeout sequences and randomized ops vs a rule-level model.
module tb_mem_stage;
  localparam int TB_TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_is_load = 1'b0, in_is_store = 1'b0;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic        out_valid, out_ready = 1'b0, out_err;
  logic [31:0] out_data;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;

  int checks = 0;
  int failures = 0;
`ifdef MEM_STAGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  mem_stage #(.DBITS(32), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outcome from the instruction rules, independent of how the stage sequences them.
  task automatic model(input logic ld, input logic st, input logic [31:0] addr, input logic [31:0] rd,
                       input int ackd, output logic [31:0] d, output logic e, output int reqc, output int lat);
    if (!ld && !st) begin
      d = addr; e = 1'b0; reqc = 0; lat = 1;
    end else if ((ld && st) || addr[1:0] != 2'b00) begin
      d = '0; e = 1'b1; reqc = 0; lat = 1;
    end else if (TO_EN && ackd >= TB_TO) begin
      d = '0; e = 1'b1; reqc = TB_TO; lat = TB_TO + 1;
    end else begin
      d = st ? 32'h0 : rd; e = 1'b0; reqc = ackd + 1; lat = ackd + 2;
    end
  endtask

  // Drives one instruction from IDLE (called at a negedge), acts as the bus, holds RESP for rdyd cycles.
  task automatic run_op(input logic ld, input logic st, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int ackd, input int rdyd,
                        output logic [31:0] d, output logic e, output int reqc, output int lat,
                        output logic busok, output logic stable);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_addr = addr; in_wdata = wd;
    out_ready = 1'b0;
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; mem_ack = 1'b0;
    lat = 1; reqc = 0; busok = 1'b1; stable = 1'b1;
    while (!out_valid && lat < 100) begin
      if (mem_req) begin
        reqc++;
        if (mem_addr !== addr || mem_we !== st || (st && mem_wdata !== wd)) busok = 1'b0;
        mem_ack = (reqc > ackd);
        mem_rdata = mem_ack ? rd : $urandom;
      end
      @(negedge clk);
      lat++;
    end
    mem_ack = 1'b0;
    d = out_data; e = out_err;
    if (mem_req) busok = 1'b0;
    for (int i = 0; i < rdyd; i++) begin
      in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0; in_addr = 32'h0000_0BAD;
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!out_valid || out_data !== d || out_err !== e || in_ready || mem_req) stable = 1'b0;
    end
    in_valid = 1'b0; mem_ack = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (!in_ready || out_valid || mem_req) stable = 1'b0;
  endtask

  typedef struct {
    logic ld; logic st; logic [31:0] addr; logic [31:0] wd; logic [31:0] rd; int ackd; int rdyd;
    logic [31:0] exp_d; logic exp_e; int exp_reqc; int exp_lat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] d, md;
    logic        e, me, busok, stable;
    int          reqc, lat, mreqc, mlat;

    tbl[0] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0,         32'h0,         0, 0, 32'h0000_1234, 1'b0, 0, 1};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3, 0, 32'hDEAD_BEEF, 1'b0, 4, 5};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_0001, 32'h1234_5678, 0, 0, 32'h0,         1'b0, 1, 2};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,         32'h5555_5555, 0, 0, 32'h0,         1'b1, 0, 1};
    tbl[4] = '{1'b1, 1'b1, 32'h0000_0300, 32'h1,         32'h5555_5555, 0, 0, 32'h0,         1'b1, 0, 1};
    tbl[5] = '{1'b0, 1'b1, 32'h0000_0201, 32'h2,         32'h0,         0, 0, 32'h0,         1'b1, 0, 1};
    tbl[6] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         0, 1, 32'hFFFF_FFFF, 1'b0, 0, 1};
    tbl[7] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         32'h0000_0001, 1, 5, 32'h0000_0001, 1'b0, 2, 3};
    tbl[8] = '{1'b0, 1'b1, 32'h0000_0208, 32'hA5A5_5A5A, 32'hFFFF_0000, 2, 1, 32'h0,         1'b0, 3, 4};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    foreach (tbl[i]) begin
      run_op(tbl[i].ld, tbl[i].st, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].ackd, tbl[i].rdyd,
             d, e, reqc, lat, busok, stable);
      chk($sformatf("vec%0d_data", i), d, tbl[i].exp_d);
      chk($sformatf("vec%0d_err", i), e, tbl[i].exp_e);
      chk($sformatf("vec%0d_req_cycles", i), reqc, tbl[i].exp_reqc);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("vec%0d_bus", i), busok, 1'b1);
      chk($sformatf("vec%0d_resp_hold", i), stable, 1'b1);
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    run_op(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 1000, 0, d, e, reqc, lat, busok, stable);
    chk("timeout_data", d, 32'h0);
    chk("timeout_err", e, 1'b1);
    chk("timeout_req_cycles", reqc, TB_TO);
    chk("timeout_latency", lat, TB_TO + 1);
`endif

    // Reset pulsed while a load is waiting on the bus.
    in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_addr = 32'h0000_0500;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midreq_req_up", mem_req, 1'b1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreq_rst_mem_req", mem_req, 1'b0);
    chk("midreq_rst_out_valid", out_valid, 1'b0);
    chk("midreq_rst_out_data", out_data, 32'h0);
    chk("midreq_rst_out_err", out_err, 1'b0);
    chk("midreq_rst_mem_addr", mem_addr, 32'h0);
    chk("midreq_rst_mem_we", mem_we, 1'b0);
    chk("midreq_rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midreq_after_in_ready", in_ready, 1'b1);
    chk("midreq_after_out_valid", out_valid, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic ld, st;
      logic [31:0] addr, wd, rd;
      int ackd, rdyd;
      ld = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      wd = $urandom; rd = $urandom;
      ackd = $urandom_range(0, 5);
      rdyd = $urandom_range(0, 2);
      model(ld, st, addr, rd, ackd, md, me, mreqc, mlat);
      run_op(ld, st, addr, wd, rd, ackd, rdyd, d, e, reqc, lat, busok, stable);
      chk($sformatf("rnd%0d_data", n), d, md);
      chk($sformatf("rnd%0d_err", n), e, me);
      chk($sformatf("rnd%0d_req_cycles", n), reqc, mreqc);
      chk($sformatf("rnd%0d_latency", n), lat, mlat);
      chk($sformatf("rnd%0d_bus", n), busok, 1'b1);
      chk($sformatf("rnd%0d_resp_hold", n), stable, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage directly downstream of the execute stage. Takes the ALU result (used as the effective address, or passed through for non-memory ops) and the second register operand (store data). Performs at most one word load or store per instruction over a simple req/ack data-memory bus, then hands a single result to writeback over a valid/ready handshake. Holds one instruction at a time; upstream stalls while it is busy.

## Interface
- DBITS, 32, data/address width; must be a multiple of 8, minimum 16
- TIMEOUT_CYCLES, 255, maximum cycles in REQ before a bus-timeout error; only used with the timeout feature
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready
- in_is_load  in  1  instruction is a word load
- in_is_store  in  1  instruction is a word store
- in_addr  in  DBITS  ALU result: effective address, or result for non-memory ops
- in_wdata  in  DBITS  store data (second register operand)
- out_valid  out  1  result available to writeback
- out_ready  in  1  writeback accepts; transfer when out_valid && out_ready
- out_data  out  DBITS  load data, passed-through ALU result, or 0
- out_err  out  1  access error (illegal op, misaligned, timeout)
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  DBITS  bus address; valid while mem_req
- mem_wdata  out  DBITS  bus write data; valid while mem_req && mem_we
- mem_ack  in  1  bus completes access in the cycle it is sampled high with mem_req
- mem_rdata  in  DBITS  read data; valid in the ack cycle of a read

## Operation
- States: IDLE, REQ, RESP. in_ready = (state == IDLE).
- Accept in IDLE latches in_addr, in_wdata, op flags:
  - neither flag: out_data = in_addr, out_err = 0, go RESP.
  - both flags: illegal; out_data = 0, out_err = 1, no bus access, go RESP.
  - load/store with in_addr[1:0] != 0: misaligned; out_data = 0, out_err = 1, no bus access, go RESP.
  - otherwise: go REQ; mem_addr = in_addr, mem_we = in_is_store, mem_wdata = in_wdata.
- REQ: mem_req = 1, address/data/we stable. On mem_ack: load captures mem_rdata into out_data; store sets out_data = 0; out_err = 0; go RESP. mem_req deasserts the cycle after ack.
- RESP: out_valid = 1, out_data/out_err stable until out_ready; on out_ready go IDLE.
- mem_ack outside REQ is ignored. No new bus request is issued while RESP is pending.
- Reset values: state IDLE; in_ready 1 after reset deasserts; out_valid, out_data, out_err, mem_req, mem_we, mem_addr, mem_wdata all 0. Reset asserted mid-REQ drops mem_req immediately (asynchronous) and discards the instruction.

## Timing
- Non-memory or error op: accepted at edge N, out_valid high from N+1.
- Memory op: mem_req high from N+1; ack sampled at edge N+1+k (k >= 0; ack in first REQ cycle allowed); out_valid high from N+2+k. Minimum load/store latency 2 cycles.
- out_ready held high in RESP: IDLE next cycle, in_ready high; sustained throughput one instruction per 2 cycles (non-memory), 3+k cycles (memory).
- No combinational path from in_* to out_* or mem_*; all outputs registered or derived from state.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined: cycle counter cleared on REQ entry, increments per REQ cycle without ack; when it reaches TIMEOUT_CYCLES without ack, mem_req drops, out_data = 0, out_err = 1, go RESP. Ack in the same cycle the limit is reached wins (normal completion).
- Not defined: REQ waits indefinitely for mem_ack; no counter logic; TIMEOUT_CYCLES ignored.

## Test plan
- Non-memory op, in_addr = 0x0000_1234, out_ready = 1 -> out_valid one cycle after accept, out_data = 0x0000_1234, out_err = 0, no mem_req.
- Load addr 0x100, mem_ack 3 cycles into REQ with mem_rdata = 0xDEAD_BEEF -> mem_req/mem_we = 1/0 for exactly 4 cycles, out_data = 0xDEAD_BEEF, out_err = 0.
- Store addr 0x200 data 0xCAFE_0001, ack in first REQ cycle -> one-cycle mem_req with mem_we = 1, mem_wdata = 0xCAFE_0001; out_data = 0, out_valid 2 cycles after accept.
- Load addr 0x102 and a second op with both flags set -> each: no mem_req, out_err = 1, out_data = 0.
- out_ready low 5 cycles in RESP -> out_valid/out_data stable, in_ready 0, next op blocked until handshake completes.
- MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> mem_req for 4 cycles, then out_err = 1; reset_n pulsed mid-REQ in separate run -> mem_req 0 immediately, all outputs 0.
